// File: rtl/sdram_frame_writer_if.sv
// FIFO read port and Avalon-MM write port seen by sdram_frame_writer.
// master: writer side; slave: FIFO + SDRAM controller side.
interface sdram_frame_writer_if #(
  parameter int ADDR_W     = 25,
  parameter int WORD_BYTES = 2
);
  logic                    oFIFO_RDREQ;
  logic [7:0]              iFIFO_DATA;
  logic                    iFIFO_EMPTY;
  logic [ADDR_W-1:0]       oSDRAM_ADDR;
  logic                    oSDRAM_WRITE;
  logic [8*WORD_BYTES-1:0] oSDRAM_WRDATA;
  logic [WORD_BYTES-1:0]   oSDRAM_BYTEEN;
  logic                    iSDRAM_WAITREQUEST;

  modport master (
    output oFIFO_RDREQ,
    input  iFIFO_DATA,
    input  iFIFO_EMPTY,
    output oSDRAM_ADDR,
    output oSDRAM_WRITE,
    output oSDRAM_WRDATA,
    output oSDRAM_BYTEEN,
    input  iSDRAM_WAITREQUEST
  );

  modport slave (
    input  oFIFO_RDREQ,
    output iFIFO_DATA,
    output iFIFO_EMPTY,
    input  oSDRAM_ADDR,
    input  oSDRAM_WRITE,
    input  oSDRAM_WRDATA,
    input  oSDRAM_BYTEEN,
    output iSDRAM_WAITREQUEST
  );
endinterface

// File: rtl/sdram_frame_writer.sv
// Packs FIFO bytes little-endian into SDRAM words and writes all frames.
// Ports: iCLK/iRST_N, iTRIGGER/iNUM_IMAGES start, bus (FIFO + Avalon),
// oBUSY/oFRAME_IDX/oDONE/oERROR status.
// Optional stall watchdog: define SDRAM_FRAME_WRITER_WATCHDOG_EN.
module sdram_frame_writer #(
  parameter int FRAME_BYTES_LOG2 = 20,
  parameter int WORD_BYTES       = 2,
  parameter int ADDR_W           = 25,
  parameter int BASE_ADDR        = 0,
  parameter int WDT_LOG2         = 24
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iTRIGGER,
  input  logic [6:0] iNUM_IMAGES,
  sdram_frame_writer_if.master bus,
  output logic       oBUSY,
  output logic [5:0] oFRAME_IDX,
  output logic       oDONE,
  output logic       oERROR
);
  localparam int WB_LOG2  = (WORD_BYTES == 4) ? 2 : 1;
  localparam int WPF_LOG2 = FRAME_BYTES_LOG2 - WB_LOG2;
  localparam logic [2:0] WB = 3'(WORD_BYTES);
  localparam logic [2:0] WB_M1 = 3'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_FILL, S_WRITE, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [26:0]             r_total, r_wcnt;
  logic [2:0]              r_req, r_byte;
  logic                    r_vld;
  logic [8*WORD_BYTES-1:0] r_data;
  logic                    w_rdreq, w_accept;
  logic                    w_last, w_last_byte;
  logic                    w_abort, w_start;
  logic [26:0]             w_total;

  assign w_start  = (r_state == S_IDLE) && iTRIGGER;
  assign w_total  = 27'(iNUM_IMAGES) << WPF_LOG2;
  assign w_rdreq  = (r_state == S_FILL)
                  && !bus.iFIFO_EMPTY
                  && (r_req < WB);
  assign w_accept = (r_state == S_WRITE)
                  && !bus.iSDRAM_WAITREQUEST;
  assign w_last   = (r_wcnt + 27'd1) == r_total;
  // r_vld marks q holding the byte requested last cycle
  assign w_last_byte = r_vld && (r_byte == WB_M1);

`ifdef SDRAM_FRAME_WRITER_WATCHDOG_EN
  localparam logic [WDT_LOG2-1:0] WDT_MAX =
    WDT_LOG2'((1 << WDT_LOG2) - 2);
  logic [WDT_LOG2-1:0] r_wdt;
  logic                r_err;

  // Fires on the (2^WDT_LOG2-1)th consecutive empty FILL cycle
  assign w_abort = (r_state == S_FILL)
                 && bus.iFIFO_EMPTY
                 && (r_wdt == WDT_MAX)
                 && !w_last_byte;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_wdt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == S_FILL) && bus.iFIFO_EMPTY && !w_abort)
        r_wdt <= r_wdt + 1'b1;
      else
        r_wdt <= '0;
      if (w_start)
        r_err <= 1'b0;
      else if (w_abort)
        r_err <= 1'b1;
    end
  end

  assign oERROR = r_err;
`else
  assign w_abort = 1'b0;
  assign oERROR  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (iTRIGGER)
          w_next = (iNUM_IMAGES == 7'd0) ? S_DONE : S_FILL;
      S_FILL:
        if (w_last_byte)  w_next = S_WRITE;
        else if (w_abort) w_next = S_IDLE;
      S_WRITE:
        if (w_accept)
          w_next = w_last ? S_DONE : S_FILL;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_total <= '0;
      r_wcnt  <= '0;
      r_req   <= '0;
      r_byte  <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_vld   <= w_rdreq;
      if (w_start) begin
        r_total <= w_total;
        r_wcnt  <= '0;
        r_req   <= '0;
        r_byte  <= '0;
      end
      if (w_rdreq)
        r_req <= r_req + 3'd1;
      if (r_vld) begin
        for (int i = 0; i < WORD_BYTES; i++)
          if (r_byte == 3'(i))
            r_data[8*i +: 8] <= bus.iFIFO_DATA;
        r_byte <= r_byte + 3'd1;
      end
      if (w_last_byte || w_abort) begin
        r_req  <= '0;
        r_byte <= '0;
      end
      if (w_accept)
        r_wcnt <= r_wcnt + 27'd1;
    end
  end

  assign bus.oFIFO_RDREQ   = w_rdreq;
  assign bus.oSDRAM_WRITE  = (r_state == S_WRITE);
  assign bus.oSDRAM_ADDR   = ADDR_W'(BASE_ADDR)
                           + ADDR_W'(r_wcnt);
  assign bus.oSDRAM_WRDATA = r_data;
  assign bus.oSDRAM_BYTEEN = '1;
  assign oBUSY      = (r_state != S_IDLE);
  assign oDONE      = (r_state == S_DONE);
  assign oFRAME_IDX = 6'(r_wcnt >> WPF_LOG2);
endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer (16-byte frames, 2-byte words).
// FIFO/SDRAM models, negedge monitor, one task per scenario.
module tb_sdram_frame_writer;
  localparam int FB  = 4;
  localparam int WB  = 2;
  localparam int AW  = 25;
  localparam int WDT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [6:0] num = 7'd0;
  logic       busy, done, err;
  logic [5:0] fidx;

  int n_checks = 0;
  int n_err = 0;

  sdram_frame_writer_if #(.ADDR_W(AW), .WORD_BYTES(WB)) bus();

  sdram_frame_writer #(
    .FRAME_BYTES_LOG2(FB), .WORD_BYTES(WB), .ADDR_W(AW),
    .BASE_ADDR(0), .WDT_LOG2(WDT)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTRIGGER(trig),
    .iNUM_IMAGES(num), .bus(bus), .oBUSY(busy),
    .oFRAME_IDX(fidx), .oDONE(done), .oERROR(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: q = byte index, valid one cycle after rdreq
  int   rp = 0;
  int   fifo_len = 32;
  logic fifo_rst = 1'b0;
  logic gate = 1'b1;
  assign bus.iFIFO_EMPTY = !gate || (rp >= fifo_len);
  always @(posedge clk) begin
    if (fifo_rst) rp <= 0;
    else if (bus.oFIFO_RDREQ && !bus.iFIFO_EMPTY) begin
      bus.iFIFO_DATA <= 8'(rp);
      rp <= rp + 1;
    end
  end

  logic gap_mode = 1'b0;
  int   gap_left = 0;
  always @(posedge clk) begin
    #1;
    if (!gap_mode) begin
      gate = 1'b1; gap_left = 0;
    end else if (gap_left > 0) begin
      gate = 1'b0; gap_left--;
    end else if ($urandom_range(0, 3) == 0) begin
      gate = 1'b0; gap_left = $urandom_range(0, 9);
    end else gate = 1'b1;
  end

  logic          stall_mode = 1'b0;
  int            stall_max = 5;
  int            stall_cnt = 0;
  logic [AW-1:0] stall_addr = AW'(3);
  logic          wreq = 1'b0;
  assign bus.iSDRAM_WAITREQUEST = wreq;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      wreq = 1'b0; stall_cnt = 0;
    end else if (bus.oSDRAM_WRITE
             && bus.oSDRAM_ADDR == stall_addr
             && stall_cnt < stall_max) begin
      wreq = 1'b1; stall_cnt++;
    end else wreq = 1'b0;
  end

  // Monitor: accepted writes and event counters
  logic [AW-1:0] q_addr[$];
  logic [15:0]   q_data[$];
  logic [5:0]    q_fidx[$];
  int            q_cyc[$];
  int n_rd = 0, n_rd_empty = 0, n_rd_wr = 0;
  int n_done = 0, n_a3 = 0, n_a3_bad = 0;
  always @(negedge clk) begin
    if (bus.oSDRAM_WRITE && !bus.iSDRAM_WAITREQUEST) begin
      q_addr.push_back(bus.oSDRAM_ADDR);
      q_data.push_back(bus.oSDRAM_WRDATA);
      q_fidx.push_back(fidx);
      q_cyc.push_back(cyc);
    end
    if (bus.oFIFO_RDREQ) n_rd++;
    if (bus.oFIFO_RDREQ && bus.iFIFO_EMPTY) n_rd_empty++;
    if (bus.oFIFO_RDREQ && bus.oSDRAM_WRITE) n_rd_wr++;
    if (done) n_done++;
    if (bus.oSDRAM_WRITE && bus.oSDRAM_ADDR == AW'(3)) begin
      n_a3++;
      if (bus.oSDRAM_WRDATA !== 16'h0706) n_a3_bad++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fifo_reset();
    step(1); fifo_rst = 1'b1;
    step(1); fifo_rst = 1'b0;
  endtask

  task automatic pulse_trig(input logic [6:0] n);
    step(1); num = n; trig = 1'b1;
    step(1); trig = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (done) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic check_seq(input string nm, input int base);
    int n;
    logic [15:0] exp;
    n = q_addr.size() - base;
    n_checks++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL %s count: got %0d want 16", nm, n);
    end
    if (n > 16) n = 16;
    for (int k = 0; k < n; k++) begin
      exp = {8'(2*k+1), 8'(2*k)};
      n_checks++;
      if (q_addr[base+k] !== AW'(k)
          || q_data[base+k] !== exp
          || q_fidx[base+k] !== 6'(k / 8)) begin
        n_err++;
        $display("FAIL %s word%0d: a=%0d d=%h f=%0d want a=%0d d=%h f=%0d",
          nm, k, q_addr[base+k], q_data[base+k], q_fidx[base+k],
          k, exp, k / 8);
      end
    end
  endtask

  task automatic test_reset();
    trig = 1'b1; num = 7'd2;
    step(3);
    trig = 1'b0;
    n_checks++;
    if ({bus.oSDRAM_WRITE, bus.oFIFO_RDREQ, busy, done, err}
        !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 00000",
        {bus.oSDRAM_WRITE, bus.oFIFO_RDREQ, busy, done, err});
    end
    n_checks++;
    if (bus.oSDRAM_ADDR !== '0 || fidx !== 6'd0
        || bus.oSDRAM_WRDATA !== 16'h0) begin
      n_err++;
      $display("FAIL reset_bus: a=%0d f=%0d d=%h want 0",
        bus.oSDRAM_ADDR, fidx, bus.oSDRAM_WRDATA);
    end
    n_checks++;
    if (bus.oSDRAM_BYTEEN !== 2'b11) begin
      n_err++;
      $display("FAIL reset_byteen: got %b want 11",
        bus.oSDRAM_BYTEEN);
    end
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_trig: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int b, r0, d0, e0;
    bit ok;
    fifo_reset();
    b = q_addr.size(); r0 = n_rd; d0 = n_done; e0 = n_rd_empty;
    pulse_trig(7'd2);
    wait_done(300, ok);
    step(3);
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL basic_done: timeout got 0 want 1");
    end
    check_seq("basic", b);
    n_checks++;
    if (q_addr.size() >= b + 2
        && q_cyc[b+1] - q_cyc[b] !== 4) begin
      n_err++;
      $display("FAIL basic_rate: got %0d want 4",
        q_cyc[b+1] - q_cyc[b]);
    end
    n_checks++;
    if (n_rd - r0 !== 32 || n_rd_empty - e0 !== 0) begin
      n_err++;
      $display("FAIL basic_reads: got %0d/%0d want 32/0",
        n_rd - r0, n_rd_empty - e0);
    end
    n_checks++;
    if (n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL basic_pulses: got %0d want 1", n_done - d0);
    end
    n_checks++;
    if (fidx !== 6'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: f=%0d busy=%b want 2/0", fidx, busy);
    end
  endtask

  task automatic test_stall();
    int b, r0, a0, ab0, w0;
    bit ok;
    fifo_reset();
    stall_mode = 1'b1; stall_max = 5; stall_addr = AW'(3);
    b = q_addr.size(); r0 = n_rd;
    a0 = n_a3; ab0 = n_a3_bad; w0 = n_rd_wr;
    pulse_trig(7'd2);
    wait_done(300, ok);
    step(3);
    stall_mode = 1'b0;
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL stall_done: timeout got 0 want 1");
    end
    check_seq("stall", b);
    n_checks++;
    if (n_a3 - a0 !== 6 || n_a3_bad - ab0 !== 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d cyc %0d bad want 6/0",
        n_a3 - a0, n_a3_bad - ab0);
    end
    n_checks++;
    if (n_rd - r0 !== 32 || n_rd_wr - w0 !== 0) begin
      n_err++;
      $display("FAIL stall_reads: got %0d/%0d want 32/0",
        n_rd - r0, n_rd_wr - w0);
    end
  endtask

  task automatic test_zero();
    int b, r0, d0;
    b = q_addr.size(); r0 = n_rd; d0 = n_done;
    pulse_trig(7'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_pulse: done=%b busy=%b want 1/1", done, busy);
    end
    step(1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_end: done=%b busy=%b want 0/0", done, busy);
    end
    step(2);
    n_checks++;
    if (n_rd - r0 !== 0 || q_addr.size() - b !== 0
        || n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL zero_traffic: rd=%0d wr=%0d dn=%0d want 0/0/1",
        n_rd - r0, q_addr.size() - b, n_done - d0);
    end
  endtask

  task automatic test_retrigger();
    int b, r0, d0, e0;
    bit ok;
    fifo_reset();
    gap_mode = 1'b1;
    b = q_addr.size(); r0 = n_rd; d0 = n_done; e0 = n_rd_empty;
    pulse_trig(7'd2);
    step(10);
    pulse_trig(7'd5);
    wait_done(1500, ok);
    step(3);
    gap_mode = 1'b0;
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL retrig_done: timeout got 0 want 1");
    end
    check_seq("retrig", b);
    n_checks++;
    if (n_rd - r0 !== 32 || n_rd_empty - e0 !== 0
        || n_done - d0 !== 1) begin
      n_err++;
      $display("FAIL retrig_cnt: rd=%0d re=%0d dn=%0d want 32/0/1",
        n_rd - r0, n_rd_empty - e0, n_done - d0);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok, hit;
    fifo_reset();
    stall_mode = 1'b1; stall_max = 1000; stall_addr = AW'(3);
    pulse_trig(7'd2);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (bus.oSDRAM_WRITE && bus.oSDRAM_ADDR == AW'(3)) hit = 1'b1;
      else step(1);
    end
    step(2);
    n_checks++;
    if (!hit || bus.oSDRAM_WRITE !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_stall: write=%b want 1", bus.oSDRAM_WRITE);
    end
    rst_n = 1'b0;
    step(1);
    n_checks++;
    if (bus.oSDRAM_WRITE !== 1'b0 || busy !== 1'b0
        || bus.oSDRAM_ADDR !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: w=%b busy=%b a=%0d want 0/0/0",
        bus.oSDRAM_WRITE, busy, bus.oSDRAM_ADDR);
    end
    rst_n = 1'b1;
    stall_mode = 1'b0;
    fifo_reset();
    b = q_addr.size();
    pulse_trig(7'd2);
    wait_done(300, ok);
    step(3);
    n_checks++;
    if (!ok || q_addr.size() <= b) begin
      n_err++; $display("FAIL rstmid_restart: timeout got 0 want 1");
    end else if (q_addr[b] !== '0 || q_data[b] !== 16'h0100) begin
      n_err++;
      $display("FAIL rstmid_first: a=%0d d=%h want 0/0100",
        q_addr[b], q_data[b]);
    end
  endtask

`ifdef SDRAM_FRAME_WRITER_WATCHDOG_EN
  task automatic test_watchdog();
    int b, d0, k;
    fifo_reset();
    fifo_len = 3;
    b = q_addr.size(); d0 = n_done;
    pulse_trig(7'd2);
    k = 0;
    while (!err && k < 100) begin step(1); k++; end
    step(2);
    n_checks++;
    if (k !== 12) begin
      n_err++;
      $display("FAIL wdt_time: got %0d want 12 cycles", k);
    end
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0
        || q_addr.size() - b !== 1 || n_done - d0 !== 0) begin
      n_err++;
      $display("FAIL wdt_state: e=%b b=%b wr=%0d dn=%0d want 1/0/1/0",
        err, busy, q_addr.size() - b, n_done - d0);
    end
    fifo_len = 32;
    pulse_trig(7'd0);
    n_checks++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL wdt_clear: got %b want 0", err);
    end
    step(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_retrigger();
    test_reset_mid();
`ifdef SDRAM_FRAME_WRITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_err);
    $finish;
  end
endmodule
